// File: rtl/key_pkg.sv
// key_pkg: symbol codes, scheduler FSM states and key classification shared with controller_keyboard users
package key_pkg;
  localparam logic [7:0] CODE_NULL   = 8'd0;
  localparam logic [7:0] CODE_A      = 8'd1;
  localparam logic [7:0] CODE_CAP_A  = 8'd27;
  localparam logic [7:0] CODE_DOLLAR = 8'd53;
  localparam logic [7:0] CODE_END    = 8'd61;
  localparam logic [7:0] CODE_BKSP   = 8'd65;
  localparam logic [7:0] CODE_ENTER  = 8'd66;
  localparam logic [7:0] CODE_UP     = 8'd67;
  localparam logic [7:0] CODE_DOWN   = 8'd68;
  typedef enum logic [1:0] {ST_IDLE, ST_HELD_DELAY, ST_HELD_REPEAT, ST_HELD_NOREP} key_state_t;
  function automatic logic is_norepeat(input logic [7:0] code);
    return code == CODE_ENTER || code == CODE_UP || code == CODE_DOWN;
  endfunction
endpackage

// File: rtl/key_event_scheduler_if.sv
// key_event_scheduler_if: event stream from the scheduler to its consumer
//   out_code/out_valid/out_ready : valid/ready event handshake
//   fifo_count                   : events currently buffered
//   overflow                     : sticky dropped-event flag
//   master = scheduler side, slave = consumer side
interface key_event_scheduler_if #(parameter int DEPTH = 8);
  logic [7:0]             out_code;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  modport master (output out_code, out_valid, fifo_count, overflow, input out_ready);
  modport slave  (input out_code, out_valid, fifo_count, overflow, output out_ready);
endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo: DEPTH-entry synchronous event FIFO with flush, count and sticky overflow
//   clk_25mhz, reset (sync, active-low), flush : clock / clear controls
//   push, push_code                            : write side
//   out_code, out_valid, out_ready             : head view and pop handshake
//   count, overflow                            : occupancy and dropped-event flag
module key_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk_25mhz,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [7:0]             push_code,
  input  logic                   out_ready,
  output logic [7:0]             out_code,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push_ok;
  assign out_valid = count != '0;
  assign out_code  = out_valid ? mem[rd_ptr] : 8'd0;
  assign full      = count == (AW+1)'(DEPTH);
  assign pop       = out_valid && out_ready;
  // when full, the slot being written is the head being popped this cycle
  assign push_ok   = push && (!full || pop);
  always_ff @(posedge clk_25mhz) begin
    if (!reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) mem[wr_ptr] <= push_code;
      wr_ptr   <= wr_ptr + AW'(push_ok);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      overflow <= overflow | (push && !push_ok);
    end
  end
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: turns held key levels into buffered key events with typematic repeat
//   clk_25mhz         : system clock
//   reset             : synchronous active-low reset
//   key_code          : held symbol code, 0 = no key
//   flush             : clears buffered events and overflow
//   bus (master)      : out_code/out_valid/out_ready, fifo_count, overflow
//   KEY_AUTOREPEAT_EN : when defined, held repeatable keys auto-repeat; otherwise one event per press
module key_event_scheduler
  import key_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter int CNT_W        = 24
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic [7:0]            key_code,
  input  logic                  flush,
  key_event_scheduler_if.master bus
);
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif
  key_state_t       state, state_n;
  logic [7:0]       prev_code, push_code;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             new_press, push, delay_hit, rate_hit;
  assign new_press = key_code != CODE_NULL && key_code != prev_code;
  assign delay_hit = cnt == CNT_W'(REPEAT_DELAY - 1);
  assign rate_hit  = cnt == CNT_W'(REPEAT_RATE - 1);
  always_ff @(posedge clk_25mhz) begin
    if (!reset) begin
      state     <= ST_IDLE;
      prev_code <= CODE_NULL;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      prev_code <= key_code;
      cnt       <= cnt_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    push      = 1'b0;
    push_code = key_code;
    if (key_code == CODE_NULL) begin
      state_n = ST_IDLE;
    end else if (new_press) begin
      push    = 1'b1;
      state_n = (!AUTOREPEAT || is_norepeat(key_code)) ? ST_HELD_NOREP : ST_HELD_DELAY;
    end else if (state == ST_HELD_DELAY) begin
      push      = delay_hit;
      push_code = prev_code;
      cnt_n     = delay_hit ? '0 : cnt + CNT_W'(1);
      state_n   = delay_hit ? ST_HELD_REPEAT : ST_HELD_DELAY;
    end else if (state == ST_HELD_REPEAT) begin
      push      = rate_hit;
      push_code = prev_code;
      cnt_n     = rate_hit ? '0 : cnt + CNT_W'(1);
    end
  end
  key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_code (push_code),
    .out_ready (bus.out_ready),
    .out_code  (bus.out_code),
    .out_valid (bus.out_valid),
    .count     (bus.fifo_count),
    .overflow  (bus.overflow)
  );
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed scoreboard bench for key_event_scheduler (DEPTH=4, delay 20, rate 5)
module tb_key_event_scheduler;
  localparam int DEPTH = 4;
  localparam int RD    = 20;
  localparam int RR    = 5;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b0;
  logic       flush     = 1'b0;
  logic [7:0] key_code  = 8'd0;
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_c[$];
  int         exp_t[$];
  key_event_scheduler_if #(.DEPTH(DEPTH)) bus();
  key_event_scheduler #(
    .DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .key_code  (key_code),
    .flush     (flush),
    .bus       (bus.master)
  );
  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc++;
  // consumer side: every accepted event is matched against the scoreboard
  always @(negedge clk_25mhz) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      tests++;
      assert (exp_c.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_event observed code=%0d at cycle %0d, expected no event", bus.out_code, cyc);
      end
      if (exp_c.size() > 0) begin
        logic [7:0] c;
        int t;
        c = exp_c.pop_front();
        t = exp_t.pop_front();
        tests++;
        assert (bus.out_code === c) else begin
          fails++;
          $error("FAIL event_code observed=%0d expected=%0d", bus.out_code, c);
        end
        if (t >= 0) begin
          tests++;
          assert (cyc === t) else begin
            fails++;
            $error("FAIL event_cycle code=%0d observed=%0d expected=%0d", c, cyc, t);
          end
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic expect_ev(input logic [7:0] code, input int t);
    exp_c.push_back(code);
    exp_t.push_back(t);
  endtask
  task automatic check_drained(input string tag);
    check(tag, exp_c.size(), 0);
    exp_c.delete();
    exp_t.delete();
  endtask
  initial begin
    int c0;
    bus.out_ready = 1'b0;
    tick(2);
    check("rst_valid", bus.out_valid, 0);
    check("rst_code", bus.out_code, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_overflow", bus.overflow, 0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick(1);
    // single press, one-cycle latency
    expect_ev(8'd1, cyc + 1);
    key_code = 8'd1;
    tick(1);
    check("single_valid", bus.out_valid, 1);
    check("single_code", bus.out_code, 1);
    tick(2);
    key_code = 8'd0;
    tick(5);
    check("single_valid_low", bus.out_valid, 0);
    check_drained("single_drain");
    // auto-repeat on a repeatable key
    c0 = cyc;
    expect_ev(8'd27, c0 + 1);
    if (AR) for (int off = RD; off < 40; off += RR) expect_ev(8'd27, c0 + 1 + off);
    key_code = 8'd27;
    tick(40);
    key_code = 8'd0;
    tick(10);
    check_drained("repeat_drain");
    // no-repeat keys, including a direct change between two of them
    c0 = cyc;
    expect_ev(8'd66, c0 + 1);
    key_code = 8'd66;
    tick(40);
    key_code = 8'd0;
    tick(3);
    c0 = cyc;
    expect_ev(8'd67, c0 + 1);
    expect_ev(8'd68, c0 + 4);
    key_code = 8'd67;
    tick(3);
    key_code = 8'd68;
    tick(30);
    key_code = 8'd0;
    tick(5);
    check_drained("norep_drain");
    // overflow with the consumer stalled
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      key_code = 8'(k);
      if (k <= DEPTH) expect_ev(8'(k), -1);
      tick(1);
    end
    key_code = 8'd0;
    tick(1);
    check("ovf_count", bus.fifo_count, DEPTH);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_head", bus.out_code, 1);
    bus.out_ready = 1'b1;
    tick(6);
    check_drained("ovf_drain");
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_empty", bus.fifo_count, 0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_clears_ovf", bus.overflow, 0);
    // full FIFO with simultaneous push and pop
    bus.out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      key_code = 8'(k);
      expect_ev(8'(k), -1);
      tick(1);
    end
    key_code = 8'd0;
    tick(1);
    check("full_count", bus.fifo_count, DEPTH);
    key_code = 8'd9;
    bus.out_ready = 1'b1;
    expect_ev(8'd9, -1);
    tick(1);
    bus.out_ready = 1'b0;
    key_code = 8'd0;
    check("pushpop_count", bus.fifo_count, DEPTH);
    check("pushpop_overflow", bus.overflow, 0);
    check("pushpop_head", bus.out_code, 2);
    bus.out_ready = 1'b1;
    tick(6);
    check_drained("pushpop_drain");
    // reset in the middle of a repeating hold
    c0 = cyc;
    expect_ev(8'd5, c0 + 1);
    if (AR) begin
      expect_ev(8'd5, c0 + 1 + RD);
      expect_ev(8'd5, c0 + 1 + RD + RR);
    end
    key_code = 8'd5;
    tick(27);
    check_drained("prereset_drain");
    reset = 1'b0;
    tick(1);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_code", bus.out_code, 0);
    check("midrst_count", bus.fifo_count, 0);
    check("midrst_overflow", bus.overflow, 0);
    tick(1);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    c0 = cyc;
    tick(1);
    check("fresh_count", bus.fifo_count, 1);
    check("fresh_code", bus.out_code, 5);
    tick(1);
    // flush with the key still held: the fresh event is dropped, no re-trigger
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_count", bus.fifo_count, 0);
    check("flush_valid", bus.out_valid, 0);
    if (AR) begin
      expect_ev(8'd5, c0 + 1 + RD);
      expect_ev(8'd5, c0 + 1 + RD + RR);
    end
    tick(24);
    key_code = 8'd0;
    tick(5);
    check_drained("flush_hold_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits between controller_keyboard (level-style 8-bit symbol code; code_null = 0 while idle or blocked) and the consumer (line editor / lambda evaluator front end).
- Turns the held-key level into discrete key events and generates typematic auto-repeat for held keys.
- Buffers events in a small FIFO and hands them out over a valid/ready handshake.
- Decouples keyboard timing from the consumer's processing rate.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPEAT_DELAY, 12500000, cycles a key must stay held before the first repeat (0.5 s at 25 MHz); minimum 2.
- REPEAT_RATE, 2500000, cycles between later repeats (100 ms); minimum 2.
- CNT_W, 24, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk_25mhz  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- key_code  in  8  symbol code from controller_keyboard; 0 = no key.
- flush  in  1  synchronous clear of FIFO contents and overflow flag.
- out_code  out  8  event code at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- fifo_count  out  $clog2(DEPTH)+1  number of stored events.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE, prev_code=0, counter=0, FIFO empty. Outputs: out_valid=0, out_code=0, fifo_count=0, overflow=0.
- prev_code samples key_code every cycle.
- new_press = key_code != 0 && key_code != prev_code. It is decided combinationally in the cycle key_code first changes.
- FSM states:
  - IDLE.
  - HELD_DELAY: waiting for first repeat.
  - HELD_REPEAT: repeating.
  - HELD_NOREP: key held, no repeat.
- Transitions, priority top-down:
  - key_code == 0 → IDLE, counter=0, no push.
  - new_press (any state) → push key_code, counter=0. Go to HELD_NOREP if the code is 66/67/68 (enter/up/down), else HELD_DELAY.
  - HELD_DELAY: counter+1 per cycle. At counter == REPEAT_DELAY-1: push prev_code, counter=0, go to HELD_REPEAT.
  - HELD_REPEAT: at counter == REPEAT_RATE-1: push, counter=0.
  - HELD_NOREP: hold, counter frozen at 0.
- Latency: key_code changes in cycle C. If the FIFO was empty, out_valid=1 and out_code=new code in cycle C+1.
- FIFO:
  - out_code and out_valid are registered views of the head.
  - Pop when out_valid && out_ready.
  - Push is accepted when fifo_count < DEPTH, or when a pop occurs in the same cycle (full + push + pop: count stays DEPTH, order preserved).
  - Push and pop on an empty FIFO: push only (out_valid still 0 that cycle, so no pop).
  - Pointers wrap modulo DEPTH; count is one bit wider.
  - Rejected push: event dropped, overflow ← 1, held until flush or reset.
- flush: empties FIFO next cycle (out_valid=0, fifo_count=0) and clears overflow. FSM and prev_code are unaffected, so a held key does not re-trigger. A push in the flush cycle is discarded.
- Reset mid-operation: all state cleared. A key still held after reset is treated as a new press on the first cycle after reset releases, because prev_code is 0.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- Defined: auto-repeat as described.
- Undefined: HELD_DELAY and HELD_REPEAT are never entered; every non-null press goes to HELD_NOREP. Exactly one event per press. The counter logic and REPEAT_* parameters are unused (parameters are kept so the port/parameter list is unchanged).

Decomposition:
- Shared package key_pkg:
  - Symbol code constants: CODE_NULL=0, CODE_A=1, CODE_CAP_A=27, CODE_DOLLAR=53 … CODE_END=61, CODE_BKSP=65, CODE_ENTER=66, CODE_UP=67, CODE_DOWN=68.
  - FSM state enum.
  - is_norepeat() function (also used by controller_keyboard users).
- One sub-module, key_event_fifo: a synchronous DEPTH-entry FIFO with push/pop/flush, count, full/empty and registered head.

Test Plan (sim parameters DEPTH=4, REPEAT_DELAY=20, REPEAT_RATE=5):
- Single press: key_code 0→1 for 3 cycles, then 0, out_ready=1 → exactly one event code 1; out_valid high exactly 1 cycle, starting the cycle after the change.
- Auto-repeat: hold key_code=27 for 40 cycles, out_ready=1 → events at cycle offsets 0, 20, 25, 30, 35; all code 27; then none after release.
- No-repeat key: hold key_code=66 for 40 cycles → one event 66 only. With KEY_AUTOREPEAT_EN undefined, hold 27 for 40 cycles → one event.
- Overflow: out_ready=0, press distinct codes 1,2,3,4,5 → fifo_count=4, overflow=1. Raising out_ready pops 1,2,3,4. Pulsing flush clears overflow.
- Full plus simultaneous push/pop: FIFO full with 1,2,3,4, out_ready=1 in the same cycle as a new press of 9 → count stays 4, order 2,3,4,9, overflow=0.
- Reset and flush mid-operation:
  - Hold key 5, assert reset for 2 cycles mid-repeat → all outputs 0; one fresh event 5 after release.
  - Flush while 5 is held → no re-trigger until the next repeat interval.
